// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bridge between the CPU fetch stage and an SRAM-like instruction bus.
// A one-entry tagged buffer holds the last fetched instruction. Holding the PC
// therefore costs no bus traffic. A redirect is handled by a tag mismatch, which
// starts a new fetch.
//
// Parameters:
//   MAP_KSEG  - when 1, a PC with pc[31:30]==2'b10 is issued as {3'b000, pc[28:0]}
//   NOP_INSTR - instruction returned on a miss or for a misaligned PC
//
// Optional feature (compile-time macro INST_FETCH_BYPASS_EN):
//   In WAIT, data_ok for the current pcF is forwarded to instrF in the same cycle.
//
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   pcF            - fetch PC from the datapath
//   instrF         - instruction for pcF (NOP_INSTR on a miss)
//   stall_by_iram  - fetch not yet satisfied; the datapath holds pcF
//   inst_req       - bus request, held until inst_addr_ok
//   inst_wr        - always 0 (read only)
//   inst_size      - always 2'b10 (word)
//   inst_addr      - physical fetch address; 0 while inst_req is low
//   inst_wdata     - always 0
//   inst_addr_ok   - the bus accepted the request
//   inst_data_ok   - inst_rdata is valid
//   inst_rdata     - read data
module inst_fetch_if #(
  parameter bit          MAP_KSEG  = 1'b1,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        stall_by_iram,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state;
  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic [31:0] req_pc;
  logic        req;
  logic [31:0] addr;

  logic aligned;
  logic hit;

  function automatic logic [31:0] map_addr(input logic [31:0] pc);
    if (MAP_KSEG && (pc[31:30] == 2'b10)) begin
      return {3'b000, pc[28:0]};
    end
    return pc;
  endfunction

  assign aligned = (pcF[1:0] == 2'b00);
  assign hit     = buf_valid && (buf_pc == pcF);

  assign inst_req   = req;
  assign inst_addr  = addr;
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = 32'h0;

  always_comb begin
    instrF        = hit ? buf_instr : NOP_INSTR;
    // Stall is masked during reset so the datapath is not frozen while in reset.
    stall_by_iram = !rst && aligned && !hit;
`ifdef INST_FETCH_BYPASS_EN
    if ((state == StWait) && inst_data_ok && (req_pc == pcF)) begin
      instrF        = inst_rdata;
      stall_by_iram = 1'b0;
    end
`endif
  end

  // The request and address are registered. They cannot move while inst_req is
  // high, even if pcF changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      buf_valid <= 1'b0;
      buf_pc    <= 32'h0;
      buf_instr <= NOP_INSTR;
      req_pc    <= 32'h0;
      req       <= 1'b0;
      addr      <= 32'h0;
    end else begin
      unique case (state)
        StIdle: begin
          if (aligned && !hit) begin
            req_pc <= pcF;
            req    <= 1'b1;
            addr   <= map_addr(pcF);
            state  <= StReq;
          end
        end
        StReq: begin
          if (inst_addr_ok) begin
            req   <= 1'b0;
            addr  <= 32'h0;
            state <= StWait;
          end
        end
        StWait: begin
          // Fill under req_pc, not pcF. After a redirect the stale entry misses
          // and the fetch is reissued for the new PC.
          if (inst_data_ok) begin
            buf_pc    <= req_pc;
            buf_instr <= inst_rdata;
            buf_valid <= 1'b1;
            state     <= StIdle;
          end
        end
        default: begin
          req   <= 1'b0;
          addr  <= 32'h0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_if.sv
module tb_inst_fetch_if;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        stall_by_iram;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  int errors = 0;
  int checks = 0;

`ifdef INST_FETCH_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  inst_fetch_if dut (
    .clk          (clk),
    .rst          (rst),
    .pcF          (pcF),
    .instrF       (instrF),
    .stall_by_iram(stall_by_iram),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] pc);
    rst          = 1'b1;
    pcF          = pc;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hdead_beef;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // A full miss: one IDLE cycle, then REQ with addr_ok after 'delay' cycles,
  // then WAIT with data_ok, then the hit. pcF is assumed to be set already.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                       input int delay, input string tag);
    settle();
    check({tag, "_idle_stall"}, 32'(stall_by_iram), 32'd1);
    check({tag, "_idle_req"}, 32'(inst_req), 32'd0);
    tick();
    for (int i = 0; i <= delay; i++) begin
      inst_addr_ok = (i == delay);
      settle();
      check({tag, "_req"}, 32'(inst_req), 32'd1);
      check({tag, "_addr"}, inst_addr, exp_addr);
      check({tag, "_req_stall"}, 32'(stall_by_iram), 32'd1);
      tick();
    end
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = rdata;
    settle();
    check({tag, "_wait_req"}, 32'(inst_req), 32'd0);
    check({tag, "_wait_addr"}, inst_addr, 32'h0);
    check({tag, "_wait_stall"}, 32'(stall_by_iram), Bypass ? 32'd0 : 32'd1);
    check({tag, "_wait_instr"}, instrF, Bypass ? rdata : 32'h0);
    tick();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hdead_beef;
    settle();
    check({tag, "_hit_instr"}, instrF, rdata);
    check({tag, "_hit_stall"}, 32'(stall_by_iram), 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset(32'hbfc0_0000);
    rst = 1'b1;
    settle();
    check("rst_req", 32'(inst_req), 32'd0);
    check("rst_instr", instrF, 32'h0);
    check("rst_stall", 32'(stall_by_iram), 32'd0);
    check("rst_addr", inst_addr, 32'h0);
    check("const_wr", 32'(inst_wr), 32'd0);
    check("const_size", 32'(inst_size), 32'd2);
    check("const_wdata", inst_wdata, 32'h0);
    tick();
    rst = 1'b0;

    // Scenario 1: minimum-latency miss from kseg1
    fetch(32'h1fc0_0000, 32'h3c1d_8000, 0, "s1");
    tick();

    // Hold the PC: no further bus traffic
    for (int i = 0; i < 10; i++) begin
      settle();
      check("hold_req", 32'(inst_req), 32'd0);
      check("hold_instr", instrF, 32'h3c1d_8000);
      check("hold_stall", 32'(stall_by_iram), 32'd0);
      tick();
    end

    // Redirect while in WAIT
    do_reset(32'hbfc0_0000);
    settle();
    check("rd_idle_stall", 32'(stall_by_iram), 32'd1);
    tick();
    inst_addr_ok = 1'b1;
    settle();
    check("rd_req_addr", inst_addr, 32'h1fc0_0000);
    tick();
    inst_addr_ok = 1'b0;
    pcF          = 32'hbfc0_0004;
    settle();
    check("rd_wait_stall", 32'(stall_by_iram), 32'd1);
    check("rd_wait_instr", instrF, 32'h0);
    tick();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h3c1d_8000;
    settle();
    check("rd_data_stall", 32'(stall_by_iram), 32'd1);
    check("rd_data_instr", instrF, 32'h0);
    tick();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'hdead_beef;
    // The buffer now holds the stale tag; this is the IDLE miss cycle for bfc00004.
    fetch(32'h1fc0_0004, 32'h2408_0001, 0, "rd2");
    tick();
    // Going back to the old PC hits the entry for bfc00004? No, it misses.
    pcF = 32'hbfc0_0000;
    settle();
    check("rd_old_miss", 32'(stall_by_iram), 32'd1);
    check("rd_old_instr", instrF, 32'h0);
    tick();
    // Let that refetch complete so the next test starts from IDLE
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h3c1d_8000;
    tick();
    inst_data_ok = 1'b0;

    // Misaligned PC
    pcF = 32'hbfc0_0002;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("mis_req", 32'(inst_req), 32'd0);
      check("mis_stall", 32'(stall_by_iram), 32'd0);
      check("mis_instr", instrF, 32'h0);
      tick();
    end

    // addr_ok delayed by 4 cycles, kseg0 mapping
    pcF = 32'h8000_1000;
    fetch(32'h0000_1000, 32'h1234_5678, 4, "dly");
    tick();

    // useg address passes through unmapped
    pcF = 32'h0040_0000;
    fetch(32'h0040_0000, 32'hcafe_f00d, 1, "useg");
    tick();

    // pcF change while inst_req is high does not move the address
    pcF = 32'hbfc0_0100;
    settle();
    check("stab_idle_stall", 32'(stall_by_iram), 32'd1);
    tick();
    settle();
    check("stab_addr0", inst_addr, 32'h1fc0_0100);
    tick();
    pcF = 32'hbfc0_0200;
    settle();
    check("stab_req", 32'(inst_req), 32'd1);
    check("stab_addr1", inst_addr, 32'h1fc0_0100);
    tick();
    pcF = 32'hbfc0_0100;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;

    // Reset mid-transaction; a late data_ok in IDLE must not fill the buffer
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h5555_aaaa;
    settle();
    check("late_idle_stall", 32'(stall_by_iram), 32'd1);
    check("late_idle_instr", instrF, 32'h0);
    tick();
    inst_data_ok = 1'b0;
    settle();
    check("late_after_instr", instrF, 32'h0);
    check("late_after_req", 32'(inst_req), 32'd1);
    check("late_after_addr", inst_addr, 32'h1fc0_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
